// File: rtl/mult_pkg.sv
// Shared types and sizing for the shift-and-add multiplier controller.
package mult_pkg;

    localparam int unsigned N_DEFAULT = 8;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CNT_W = cnt_width(N_DEFAULT);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ADD,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/step_counter.sv
// Counts completed add/shift steps; saturates at N-1 and flags the terminal step.
module step_counter #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) (
    input  logic clock,
    input  logic nreset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + W'(1);
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/mult_controller.sv
// Sequencing FSM for an N-bit shift-and-add multiplier driving an external AQ register.
module mult_controller
    import mult_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic clock,
    input  logic nreset,
    input  logic start,
    input  logic Q0,
    output logic load,
    output logic add,
    output logic shift,
    output logic ready,
    output logic done
);

    localparam int unsigned W = cnt_width(N);

    state_t state, next_state;
    logic   terminal;

    step_counter #(
        .N (N),
        .W (W)
    ) u_step_counter (
        .clock    (clock),
        .nreset   (nreset),
        .clear    (state == LOAD),
        .enable   (state == SHIFT),
        .terminal (terminal)
    );

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    next_state = start ? LOAD : IDLE;
            LOAD:    next_state = ADD;
            ADD:     next_state = SHIFT;
            // Last step exits before the counter would wrap.
            SHIFT:   next_state = terminal ? DONE : ADD;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load  = 1'b0;
        add   = 1'b0;
        shift = 1'b0;
        ready = 1'b0;
        done  = 1'b0;
        unique case (state)
            IDLE:    ready = 1'b1;
            LOAD:    load  = 1'b1;
            ADD:     add   = Q0;
            SHIFT:   shift = 1'b1;
            DONE:    done  = 1'b1;
            default: ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mult_controller.sv
// Bench for mult_controller with a behavioural AQ register and adder closing the loop on Q0.
module tb_mult_controller;

    logic clock = 1'b0;
    logic nreset, start, q0;
    logic load, add, shift, ready, done;

    logic [7:0] mcand = '0;
    logic [7:0] qin   = '0;
    logic [7:0] a_reg = '0;
    logic [7:0] q_reg = '0;
    logic       c_reg = 1'b0;

    int total  = 0;
    int passed = 0;

    always #5 clock = ~clock;

    assign q0 = q_reg[0];

    mult_controller #(
        .N (8)
    ) dut (
        .clock  (clock),
        .nreset (nreset),
        .start  (start),
        .Q0     (q0),
        .load   (load),
        .add    (add),
        .shift  (shift),
        .ready  (ready),
        .done   (done)
    );

    always_ff @(posedge clock) begin
        if (load) begin
            c_reg <= 1'b0;
            a_reg <= '0;
            q_reg <= qin;
        end else if (add) begin
            {c_reg, a_reg} <= {1'b0, a_reg} + {1'b0, mcand};
        end else if (shift) begin
            {c_reg, a_reg, q_reg} <= {1'b0, c_reg, a_reg, q_reg[7:1]};
        end
    end

    typedef struct {
        logic [7:0]  mc;
        logic [7:0]  mp;
        bit          toggle;
        int          prod;
        int          adds;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Runs one operation from IDLE; sample i observes cycle k+i after start is taken at edge k.
    task automatic run_op(input logic [7:0] mc, input logic [7:0] mp, input bit toggle,
                          output int loads, output int adds, output int shifts,
                          output int done_at, output int overlap, output int add_mask,
                          output int prod);
        loads = 0; adds = 0; shifts = 0; done_at = -1; overlap = 0; add_mask = 0; prod = -1;
        @(negedge clock);
        mcand = mc;
        qin   = mp;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (i > 1) begin
                @(posedge clock);
                #1;
            end
            loads  += int'(load);
            adds   += int'(add);
            shifts += int'(shift);
            if ((int'(load) + int'(add) + int'(shift)) > 1) overlap++;
            if (add && i >= 2 && i <= 16 && i % 2 == 0) add_mask |= (1 << ((i - 2) / 2));
            start = (toggle && i < 17) ? logic'(i[0]) : 1'b0;
            if (done) begin
                done_at = i;
                prod    = int'({a_reg, q_reg});
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int loads, adds, shifts, done_at, overlap, add_mask, prod, rdy, nsh;
        int load1, load2, done1, done2, ready19;

        vecs[0] = '{mc: 8'd3,   mp: 8'b10110101, toggle: 1'b1, prod: 543,   adds: 5};
        vecs[1] = '{mc: 8'd77,  mp: 8'd0,        toggle: 1'b0, prod: 0,     adds: 0};
        vecs[2] = '{mc: 8'd13,  mp: 8'd11,       toggle: 1'b0, prod: 143,   adds: 3};
        vecs[3] = '{mc: 8'd255, mp: 8'd255,      toggle: 1'b1, prod: 65025, adds: 8};
        vecs[4] = '{mc: 8'd0,   mp: 8'd200,      toggle: 0,    prod: 0,     adds: 3};

        nreset = 1'b0;
        start  = 1'b0;
        #2;
        check("reset_ready", int'(ready), 1);
        check("reset_load",  int'(load),  0);
        check("reset_add",   int'(add),   0);
        check("reset_shift", int'(shift), 0);
        check("reset_done",  int'(done),  0);
        @(negedge clock);
        nreset = 1'b1;
        @(posedge clock);
        #1;
        check("idle_ready", int'(ready), 1);

        foreach (vecs[v]) begin
            run_op(vecs[v].mc, vecs[v].mp, vecs[v].toggle,
                   loads, adds, shifts, done_at, overlap, add_mask, prod);
            check($sformatf("v%0d_loads", v),    loads,    1);
            check($sformatf("v%0d_adds", v),     adds,     vecs[v].adds);
            check($sformatf("v%0d_add_mask", v), add_mask, int'(vecs[v].mp));
            check($sformatf("v%0d_shifts", v),   shifts,   8);
            check($sformatf("v%0d_done_at", v),  done_at,  18);
            check($sformatf("v%0d_overlap", v),  overlap,  0);
            check($sformatf("v%0d_product", v),  prod,     vecs[v].prod);
            rdy = 0;
            loads = 0;
            repeat (3) begin
                @(posedge clock);
                #1;
                rdy   += int'(ready);
                loads += int'(load);
            end
            check($sformatf("v%0d_idle_ready", v), rdy,   3);
            check($sformatf("v%0d_idle_load", v),  loads, 0);
        end

        // start held high: second LOAD follows one IDLE cycle after DONE
        load1 = -1; load2 = -1; done1 = -1; done2 = -1; ready19 = -1;
        @(negedge clock);
        mcand = 8'd5;
        qin   = 8'd6;
        start = 1'b1;
        @(posedge clock);
        #1;
        for (int i = 1; i <= 45; i++) begin
            if (i > 1) begin
                @(posedge clock);
                #1;
            end
            if (load) begin
                if (load1 < 0) load1 = i;
                else if (load2 < 0) load2 = i;
            end
            if (i == 19) ready19 = int'(ready);
            if (done) begin
                if (done1 < 0) done1 = i;
                else begin
                    done2 = i;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        check("hold_load1",   load1,   1);
        check("hold_done1",   done1,   18);
        check("hold_ready19", ready19, 1);
        check("hold_load2",   load2,   20);
        check("hold_done2",   done2,   37);
        check("hold_product", int'({a_reg, q_reg}), 30);

        // asynchronous reset in the 4th SHIFT cycle
        @(posedge clock);
        #1;
        @(negedge clock);
        mcand = 8'd9;
        qin   = 8'd7;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        nsh = int'(shift);
        for (int i = 2; i <= 20 && nsh < 4; i++) begin
            @(posedge clock);
            #1;
            nsh += int'(shift);
        end
        check("mid_rst_shifts_seen", nsh, 4);
        #2;
        nreset = 1'b0;
        #1;
        check("mid_rst_ready", int'(ready), 1);
        check("mid_rst_load",  int'(load),  0);
        check("mid_rst_add",   int'(add),   0);
        check("mid_rst_shift", int'(shift), 0);
        check("mid_rst_done",  int'(done),  0);
        @(negedge clock);
        nreset = 1'b1;
        run_op(8'd9, 8'd7, 1'b0, loads, adds, shifts, done_at, overlap, add_mask, prod);
        check("post_rst_loads",   loads,   1);
        check("post_rst_adds",    adds,    3);
        check("post_rst_shifts",  shifts,  8);
        check("post_rst_done_at", done_at, 18);
        check("post_rst_product", prod,    63);

        repeat (2) @(posedge clock);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mult_controller.md
MULT_CONTROLLER -- requirements
Module: mult_controller

Interface
REQ-001 Parameter: N, default 8, number of multiplier bits.
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 nreset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a multiplication; sampled only in IDLE.
REQ-005 Q0  input  1  LSB of the AQ register (current multiplier bit).
REQ-006 load  output  1  to the AQ register's load/clear input: clears C and A, loads Qin into Q.
REQ-007 add  output  1  to the AQ register: store adder carry and Sum into C and A.
REQ-008 shift  output  1  to the AQ register: shift {C,A,Q} right by one.
REQ-009 ready  output  1  controller idle; start is accepted.
REQ-010 done  output  1  one-cycle pulse; AQ holds the final product.

Function
REQ-011 States SHALL be IDLE, LOAD, ADD, SHIFT, DONE; N-bit step counter width clog2(N).
REQ-012 IDLE: ready=1, all other outputs 0; start=1 -> LOAD, else stay.
REQ-013 LOAD: load=1 for exactly one cycle; counter cleared to 0; -> ADD.
REQ-014 ADD: add=Q0 (combinational from Q0 in this state); load=shift=0; -> SHIFT unconditionally.
REQ-015 SHIFT: shift=1 for exactly one cycle; if counter==N-1 -> DONE, else counter+1 and -> ADD.
REQ-016 DONE: done=1 for exactly one cycle, ready=0; -> IDLE.
REQ-017 At most one of load/add/shift SHALL be high in any cycle.
REQ-018 Latency: start sampled at edge k -> LOAD in cycle k+1, 2N ADD/SHIFT cycles, done high in cycle k+2N+2 (k+18 for N=8).
REQ-019 Exactly N shift pulses and at most N add pulses SHALL occur per operation.
REQ-020 start while not in IDLE SHALL be ignored; no queuing.
REQ-021 start held high continuously SHALL begin a new operation in the cycle after the return to IDLE.
REQ-022 Counter SHALL never wrap: the SHIFT with counter==N-1 exits to DONE.
REQ-023 All outputs SHALL be decoded from state (plus Q0 for add); no output glitch-dependent logic on start.

Reset
REQ-024 nreset low SHALL force IDLE and counter=0 asynchronously, in any state including mid-operation.
REQ-025 Reset values: ready=1, load=0, add=0, shift=0, done=0.
REQ-026 After nreset deasserts, the first start SHALL run a complete sequence from LOAD.

Structure
REQ-027 Package mult_pkg SHALL hold the state typedef enum (IDLE, LOAD, ADD, SHIFT, DONE), N default, and counter width constant.
REQ-028 One sub-module step_counter (clear, enable, terminal-count output) is natural; the FSM stays in mult_controller.

Verification
REQ-029 Assert nreset low -> ready=1, load=add=shift=done=0 immediately without a clock edge.
REQ-030 start pulse, Q0 driven from model of multiplier 8'b10110101 -> 1 load, add high in exactly 5 ADD cycles (bits 0,2,4,5,7), 8 shift pulses, done at cycle k+18.
REQ-031 Multiplier 8'd0 (Q0 always 0) -> zero add pulses, 8 shift pulses, done at k+18.
REQ-032 start toggled during ADD/SHIFT cycles -> no effect; start held high -> back-to-back operations separated by one IDLE cycle.
REQ-033 nreset low during 4th SHIFT -> IDLE at once, all outputs at reset values; next start gives a full 17-step sequence.
REQ-034 Integrated with AQ register and 8-bit adder: 13x11 -> AQ=16'd143; 255x255 -> AQ=16'd65025; 0x200 -> AQ=16'd0, each at done.
